// File: rtl/fnd_scan_controller.sv
// -----------------------------------------------------------------------------
// fnd_scan_controller
//   Multiplexed N-digit 7-segment (FND) driver. Time-scans a snapshot of packed
//   BCD digits onto a shared active-low segment bus, one digit common at a time.
//   Features: PWM dimming, leading-zero blanking, per-digit decimal point,
//   one dead (all-commons-off) cycle per digit slot and tear-free frame capture.
//
// Ports
//   i_clk      system clock
//   i_reset    asynchronous, active-high reset
//   i_bcd      packed digits, [3:0] = digit 0 (least significant)
//   i_dp       decimal-point request per digit
//   i_blank    1 = all digits dark (sampled every cycle)
//   i_lzb      1 = leading-zero blanking enabled
//   i_bright   PWM duty, 0 = off, 15 = full on
//   o_fnd_com  digit commons, one-hot at COM_ACT level
//   o_fndfont  segments {dp,g..a}, active-low
//   o_frame    1-cycle pulse after a new frame snapshot is taken
// -----------------------------------------------------------------------------
module fnd_scan_controller #(
  parameter int N_DIGITS = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter bit COM_ACT  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [4*N_DIGITS-1:0] i_bcd,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_blank,
  input  logic                  i_lzb,
  input  logic [3:0]            i_bright,
  output logic [N_DIGITS-1:0]   o_fnd_com,
  output logic [7:0]            o_fndfont,
  output logic                  o_frame
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int TW       = $clog2(TICK_DIV);
  localparam int IW       = $clog2(N_DIGITS);

  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] COM_OFF   = {N_DIGITS{~COM_ACT}};

  // Segment pattern (active-low {dp,g..a}) for one digit value.
  // Value A lights only the decimal point; B..F are dark.
  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0:    return 8'hC0;
      4'h1:    return 8'hF9;
      4'h2:    return 8'hA4;
      4'h3:    return 8'hB0;
      4'h4:    return 8'h99;
      4'h5:    return 8'h92;
      4'h6:    return 8'h82;
      4'h7:    return 8'hF8;
      4'h8:    return 8'h80;
      4'h9:    return 8'h90;
      4'hA:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            pwm_cnt_q, pwm_cnt_d;
  logic [4*N_DIGITS-1:0] bcd_snap_q, bcd_snap_d;
  logic [N_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [N_DIGITS-1:0]   com_q, com_d;
  logic [7:0]            font_q, font_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  snap;
  logic                  dead;
  logic                  lit;
  logic [N_DIGITS:0]     zero_above;  // [i]: digit i and every higher digit are 0
  logic [N_DIGITS-1:0]   onehot;
  logic [3:0]            cur_v;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [7:0]            cur_font;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    snap       = tick && (idx_q == IDX_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    // Inputs are only captured at the frame boundary so a frame is never torn.
    bcd_snap_d = snap ? i_bcd : bcd_snap_q;
    dp_snap_d  = snap ? i_dp  : dp_snap_q;
    frame_d    = snap;
  end

  // Leading-zero chain, evaluated from the most significant digit down.
  always_comb begin
    zero_above           = '0;
    zero_above[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (bcd_snap_q[4*i +: 4] == 4'd0);
    end
  end

  // Current-digit mux and output next-state.
  always_comb begin
    cur_v  = 4'd0;
    cur_dp = 1'b0;
    cur_lz = 1'b0;
    onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_v     = bcd_snap_q[4*i +: 4];
        cur_dp    = dp_snap_q[i];
        cur_lz    = (i != 0) && zero_above[i];
        onehot[i] = 1'b1;
      end
    end

    // tick_cnt is 0 exactly in the first cycle of each new digit slot: keep
    // every common off then so the previous digit's segments cannot ghost.
    dead = (tick_cnt_q == '0);
    lit  = !dead && !i_blank && ((i_bright == 4'hF) || (pwm_cnt_q < i_bright));

    cur_font = (i_lzb && cur_lz) ? 8'hFF : seg_of(cur_v);
    if (cur_dp) begin
      cur_font[7] = 1'b0;
    end

    com_d  = lit ? (COM_ACT ? onehot : ~onehot) : COM_OFF;
    font_d = i_blank ? 8'hFF : cur_font;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
      idx_q      <= '0;
      pwm_cnt_q  <= '0;
      bcd_snap_q <= '0;
      dp_snap_q  <= '0;
      com_q      <= COM_OFF;
      font_q     <= 8'hFF;
      frame_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      pwm_cnt_q  <= pwm_cnt_d;
      bcd_snap_q <= bcd_snap_d;
      dp_snap_q  <= dp_snap_d;
      com_q      <= com_d;
      font_q     <= font_d;
      frame_q    <= frame_d;
    end
  end

  assign o_fnd_com = com_q;
  assign o_fndfont = font_q;
  assign o_frame   = frame_q;

endmodule
